// File: rtl/ray_gen.sv
// Raster-order pinhole-camera ray generator: one ray per cycle through a 3-stage pipeline.
// Optional build macro RAY_GEN_HALF_RES_EN: step x/y by 2, reporting full-resolution coordinates.
module ray_gen #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480,
  parameter logic [31:0] STEP  = 32'h0000_00CD,
  parameter logic [31:0] FOCAL = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] lookat_1_1,
  input  logic [31:0] lookat_1_2,
  input  logic [31:0] lookat_1_3,
  input  logic [31:0] lookat_2_1,
  input  logic [31:0] lookat_2_2,
  input  logic [31:0] lookat_2_3,
  input  logic [31:0] lookat_3_1,
  input  logic [31:0] lookat_3_2,
  input  logic [31:0] lookat_3_3,
  input  logic [31:0] eye_x,
  input  logic [31:0] eye_y,
  input  logic [31:0] eye_z,
  input  logic        start,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [9:0]  out_x,
  output logic [8:0]  out_y,
  output logic [31:0] out_dir_x,
  output logic [31:0] out_dir_y,
  output logic [31:0] out_dir_z,
  output logic [31:0] out_org_x,
  output logic [31:0] out_org_y,
  output logic [31:0] out_org_z,
  output logic        busy,
  output logic        frame_done
);

`ifdef RAY_GEN_HALF_RES_EN
  localparam int unsigned PixStep = 2;
`else
  localparam int unsigned PixStep = 1;
`endif
  localparam logic [9:0]  XLast = 10'(H_RES - PixStep);
  localparam logic [8:0]  YLast = 9'(V_RES - PixStep);
  localparam logic [31:0] XHalf = 32'(H_RES / 2);
  localparam logic [31:0] YHalf = 32'(V_RES / 2);

  typedef enum logic [2:0] {StIdle, StLatch, StGen, StDrain, StDone} state_e;

  // Signed Q16.16 multiply: full 64-bit product, bits [47:16] kept.
  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    return 32'(p >> 16);
  endfunction

  state_e      state_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic [31:0] mat_in [9];
  logic [31:0] mat_q  [9];
  logic [31:0] eye_q  [3];

  logic        s1_valid_q, s1_last_q;
  logic [9:0]  s1_x_q;
  logic [8:0]  s1_y_q;
  logic [31:0] s1_u_q, s1_v_q;
  logic        s2_valid_q, s2_last_q;
  logic [9:0]  s2_x_q;
  logic [8:0]  s2_y_q;
  logic [31:0] s2_prod_q [9];
  logic        out_last_q;

  logic        adv, issue, pix_last;
  logic [31:0] u_d, v_d;
  logic [31:0] prod_d [9];
  logic [31:0] dir_d  [3];

  assign mat_in[0] = lookat_1_1;
  assign mat_in[1] = lookat_1_2;
  assign mat_in[2] = lookat_1_3;
  assign mat_in[3] = lookat_2_1;
  assign mat_in[4] = lookat_2_2;
  assign mat_in[5] = lookat_2_3;
  assign mat_in[6] = lookat_3_1;
  assign mat_in[7] = lookat_3_2;
  assign mat_in[8] = lookat_3_3;

  assign adv      = !out_valid || out_ready;
  assign issue    = (state_q == StGen) && adv;
  assign pix_last = (x_q == XLast) && (y_q == YLast);
  // Modulo-2^32 arithmetic gives the signed result directly.
  assign u_d      = (32'(x_q) - XHalf) * STEP;
  assign v_d      = (YHalf - 32'(y_q)) * STEP;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      prod_d[3*r]     = qmul(mat_q[3*r], s1_u_q);
      prod_d[3*r + 1] = qmul(mat_q[3*r + 1], s1_v_q);
      prod_d[3*r + 2] = qmul(mat_q[3*r + 2], FOCAL);
      dir_d[r]        = s2_prod_q[3*r] + s2_prod_q[3*r + 1] + s2_prod_q[3*r + 2];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLatch;
            busy    <= 1'b1;
          end
        end
        StLatch: begin
          x_q     <= '0;
          y_q     <= '0;
          state_q <= StGen;
        end
        StGen: begin
          if (adv) begin
            if (pix_last) begin
              state_q <= StDrain;
            end else if (x_q == XLast) begin
              x_q <= '0;
              y_q <= y_q + 9'(PixStep);
            end else begin
              x_q <= x_q + 10'(PixStep);
            end
          end
        end
        StDrain: begin
          if (out_valid && out_ready && out_last_q) begin
            state_q    <= StDone;
            frame_done <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) begin
        mat_q[i]     <= '0;
        s2_prod_q[i] <= '0;
      end
      for (int i = 0; i < 3; i++) eye_q[i] <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_u_q     <= '0;
      s1_v_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_x_q     <= '0;
      s2_y_q     <= '0;
      out_valid  <= 1'b0;
      out_last_q <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_dir_x  <= '0;
      out_dir_y  <= '0;
      out_dir_z  <= '0;
      out_org_x  <= '0;
      out_org_y  <= '0;
      out_org_z  <= '0;
    end else begin
      if (state_q == StLatch) begin
        for (int i = 0; i < 9; i++) mat_q[i] <= mat_in[i];
        eye_q[0] <= eye_x;
        eye_q[1] <= eye_y;
        eye_q[2] <= eye_z;
      end
      // The whole pipeline moves together; a stalled output freezes every stage.
      if (adv) begin
        s1_valid_q <= issue;
        s1_last_q  <= pix_last;
        s1_x_q     <= x_q;
        s1_y_q     <= y_q;
        s1_u_q     <= u_d;
        s1_v_q     <= v_d;
        s2_valid_q <= s1_valid_q;
        s2_last_q  <= s1_last_q;
        s2_x_q     <= s1_x_q;
        s2_y_q     <= s1_y_q;
        for (int i = 0; i < 9; i++) s2_prod_q[i] <= prod_d[i];
        out_valid  <= s2_valid_q;
        out_last_q <= s2_last_q;
        if (s2_valid_q) begin
          out_x     <= s2_x_q;
          out_y     <= s2_y_q;
          out_dir_x <= dir_d[0];
          out_dir_y <= dir_d[1];
          out_dir_z <= dir_d[2];
          out_org_x <= eye_q[0];
          out_org_y <= eye_q[1];
          out_org_z <= eye_q[2];
        end
      end
    end
  end

endmodule
